cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
Multi-cycle control stage that sits directly upstream of the 8x8 register file. It owns the PC, fetches a 32-bit instruction through a valid handshake, and decodes it. It drives the register file's READREG1/READREG2/WRITEREG/WRITEENABLE plus ALU and mux selects, then updates the PC for sequential, jump and branch flow.

Parameters:
PC_WIDTH, 32, width of PC register and PC output
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous reset, active-low; one clock domain, CLK only
INSTRUCTION  input  32  instruction word from instruction memory
INSTR_VALID  input  1  INSTRUCTION valid this cycle
ZERO  input  1  ALU zero flag, sampled at end of WB
PC  output  PC_WIDTH  current fetch address
FETCH_REQ  output  1  request instruction at PC
READREG1  output  3  register file source 1 address
READREG2  output  3  register file source 2 address
WRITEREG  output  3  register file destination address
WRITEENABLE  output  1  register file write strobe
ALUOP  output  3  ALU function select
IMM_SEL  output  1  1 = ALU operand 2 is IMMEDIATE
NEG_SEL  output  1  1 = operand 2 two's-complemented (sub/beq)
IMMEDIATE  output  8  immediate / low byte of instruction
TRAP  output  1  illegal-opcode halt flag (see Optional Feature)

Behaviour:
- Instruction fields: OP=[31:24], DEST/OFFSET=[23:16], SRC1=[15:8], SRC2/IMM=[7:0]. Register addresses use the low 3 bits of each field.
- States: FETCH, EXEC, WB (+HALT with macro). The internal IR is 32 bits.
- Reset (RESET=0, async): state=FETCH, PC=RESET_PC, IR=0. All other outputs are 0 while RESET=0, including FETCH_REQ.
- FETCH: FETCH_REQ=1.
  - Rising edge with INSTR_VALID=1: IR<=INSTRUCTION, go to EXEC.
  - Otherwise stay in FETCH; PC holds.
  - INSTR_VALID is ignored in all other states.
- EXEC, one cycle; outputs are combinational from IR:
  - READREG1=IR[10:8], READREG2=IR[2:0], WRITEREG=IR[18:16], IMMEDIATE=IR[7:0].
  - Then go to WB.
- WB, one cycle:
  - Decode outputs are held.
  - WRITEENABLE=1 only for writing opcodes; the register file writes on the edge ending WB.
  - PC updates on that edge, then the state returns to FETCH.
- Minimum latency: 3 cycles per instruction. FETCH_REQ and WRITEENABLE are each high for exactly one cycle per instruction when there is no stall.
- Decode table (ALUOP / IMM_SEL / NEG_SEL / writes):
  - loadi 0x00: 000 / 1 / 0 / yes
  - mov 0x01: 000 / 0 / 0 / yes
  - add 0x02: 001 / 0 / 0 / yes
  - sub 0x03: 001 / 0 / 1 / yes
  - and 0x04: 010 / 0 / 0 / yes
  - or 0x05: 011 / 0 / 0 / yes
  - j 0x06: 000 / 0 / 0 / no
  - beq 0x07: 001 / 0 / 1 / no
- In FETCH, the decode outputs and WRITEENABLE are 0.
- PC update: default PC+4.
  - j: PC+4 + (sext(IR[23:16])<<2).
  - beq with ZERO=1 at end of WB: same target as j. With ZERO=0: PC+4.
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- Reset asserted mid-instruction (any state): abort immediately and return to reset values. WRITEENABLE drops asynchronously and no write occurs.
- Opcode > 0x07: handled per Optional Feature.

Optional Feature:
- Macro: CPU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in EXEC goes to HALT at the next edge.
  - In HALT: TRAP=1, FETCH_REQ=0, WRITEENABLE=0, PC frozen.
  - HALT is left only by reset.
- Undefined:
  - An illegal opcode executes as a NOP: no write, PC+4.
  - The TRAP port exists and is tied to 0.

Test Plan:
1. Reset and release:
   - RESET=0 at t=0 -> PC=0, FETCH_REQ=0, WRITEENABLE=0, TRAP=0.
   - RESET=1 -> FETCH_REQ=1 in the same cycle, PC=0.
2. loadi, INSTRUCTION=0x00040038 with INSTR_VALID=1:
   - EXEC: WRITEREG=4, IMM_SEL=1, IMMEDIATE=0x38, ALUOP=000.
   - WB: WRITEENABLE=1 for one cycle.
   - Next FETCH: PC=4.
3. Fetch stall: INSTR_VALID=0 for 5 cycles -> state stays FETCH, FETCH_REQ=1, PC unchanged, WRITEENABLE=0. Then valid 0x03010203 (sub):
   - EXEC: READREG1=2, READREG2=3, WRITEREG=1, ALUOP=001, NEG_SEL=1.
   - WB: WRITEENABLE=1.
4. Control flow; WRITEENABLE never asserted in any of these:
   - j 0x06FE0000 at PC=8 -> PC=4.
   - beq 0x07030102 at PC=4 with ZERO=1 -> PC=20.
   - Same beq with ZERO=0 -> PC=8.
5. Wrap-around: PC=0xFFFFFFFC plus any add -> PC=0x00000000.
6. Illegal opcode and reset abort:
   - INSTRUCTION=0xFF000000 without macro -> no write, PC+4.
   - Same instruction with CPU_CTRL_ILLEGAL_TRAP_EN -> TRAP=1, FETCH_REQ=0 held for 10 cycles.
   - RESET=0 pulsed mid-WB of an add -> WRITEENABLE falls immediately, PC=0, TRAP=0.

Source files
------------

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Multi-cycle FETCH/EXEC/WB control stage. It owns the PC, fetches
//               instructions over a valid handshake, decodes them for the 8x8
//               register file and ALU, and redirects the PC on j/beq.
//               Optional macro CPU_CTRL_ILLEGAL_TRAP_EN adds a HALT/TRAP state.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTRUCTION,
  input  logic                INSTR_VALID,
  input  logic                ZERO,
  output logic [PC_WIDTH-1:0] PC,
  output logic                FETCH_REQ,
  output logic [2:0]          READREG1,
  output logic [2:0]          READREG2,
  output logic [2:0]          WRITEREG,
  output logic                WRITEENABLE,
  output logic [2:0]          ALUOP,
  output logic                IMM_SEL,
  output logic                NEG_SEL,
  output logic [7:0]          IMMEDIATE,
  output logic                TRAP
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;

  logic [7:0]          op;
  logic [2:0]          dec_aluop;
  logic                dec_imm, dec_neg, dec_wr;
  logic [PC_WIDTH-1:0] pc_seq, pc_tgt;
  logic                unused_ir_bits;

  assign op             = ir_q[31:24];
  assign unused_ir_bits = ^ir_q[15:11];
  assign pc_seq         = pc_q + PC_WIDTH'(4);
  // Branch/jump offset is a signed word count relative to the next sequential PC.
  assign pc_tgt         = pc_seq + {{(PC_WIDTH-10){ir_q[23]}}, ir_q[23:16], 2'b00};

  always_comb begin
    dec_aluop = 3'b000;
    dec_imm   = 1'b0;
    dec_neg   = 1'b0;
    dec_wr    = 1'b0;
    case (op)
      OP_LOADI: begin dec_aluop = 3'b000; dec_imm = 1'b1; dec_wr = 1'b1; end
      OP_MOV:   begin dec_aluop = 3'b000; dec_wr = 1'b1; end
      OP_ADD:   begin dec_aluop = 3'b001; dec_wr = 1'b1; end
      OP_SUB:   begin dec_aluop = 3'b001; dec_neg = 1'b1; dec_wr = 1'b1; end
      OP_AND:   begin dec_aluop = 3'b010; dec_wr = 1'b1; end
      OP_OR:    begin dec_aluop = 3'b011; dec_wr = 1'b1; end
      OP_J:     begin dec_aluop = 3'b000; end
      OP_BEQ:   begin dec_aluop = 3'b001; dec_neg = 1'b1; end
      default:  begin dec_aluop = 3'b000; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    FETCH_REQ   = 1'b0;
    WRITEENABLE = 1'b0;
    READREG1    = 3'b000;
    READREG2    = 3'b000;
    WRITEREG    = 3'b000;
    ALUOP       = 3'b000;
    IMM_SEL     = 1'b0;
    NEG_SEL     = 1'b0;
    IMMEDIATE   = 8'h00;

    if (state_q == S_EXEC || state_q == S_WB) begin
      READREG1  = ir_q[10:8];
      READREG2  = ir_q[2:0];
      WRITEREG  = ir_q[18:16];
      IMMEDIATE = ir_q[7:0];
      ALUOP     = dec_aluop;
      IMM_SEL   = dec_imm;
      NEG_SEL   = dec_neg;
    end

    case (state_q)
      S_FETCH: begin
        FETCH_REQ = 1'b1;
        if (INSTR_VALID) begin
          ir_d    = INSTRUCTION;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        state_d = (op > OP_BEQ) ? S_HALT : S_WB;
`else
        state_d = S_WB;
`endif
      end
      S_WB: begin
        WRITEENABLE = dec_wr;
        pc_d        = (op == OP_J || (op == OP_BEQ && ZERO)) ? pc_tgt : pc_seq;
        state_d     = S_FETCH;
      end
      default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
    endcase

    // Outputs are forced low for the whole time reset is held, not just after the edge.
    if (!RESET) begin
      FETCH_REQ   = 1'b0;
      WRITEENABLE = 1'b0;
      READREG1    = 3'b000;
      READREG2    = 3'b000;
      WRITEREG    = 3'b000;
      ALUOP       = 3'b000;
      IMM_SEL     = 1'b0;
      NEG_SEL     = 1'b0;
      IMMEDIATE   = 8'h00;
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign TRAP = RESET && (state_q == S_HALT);
`else
  assign TRAP = 1'b0;
`endif

  assign PC = pc_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Self-checking bench: directed sequence then random instructions
//               compared against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        ZERO = 1'b0;
  logic [31:0] PC;
  logic        FETCH_REQ, WRITEENABLE, IMM_SEL, NEG_SEL, TRAP;
  logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
  logic [7:0]  IMMEDIATE;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc = '0;

  // Reference decode table indexed by opcode 0..7
  logic [2:0] alu_tab [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
  logic [7:0] imm_m = 8'b0000_0001;
  logic [7:0] neg_m = 8'b1000_1000;
  logic [7:0] wr_m  = 8'b0011_1111;

  cpu_control_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .ZERO(ZERO), .PC(PC), .FETCH_REQ(FETCH_REQ), .READREG1(READREG1),
    .READREG2(READREG2), .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE),
    .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE),
    .TRAP(TRAP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                          input logic z);
    logic [31:0] seq;
    logic        taken;
    seq   = pc + 32'd4;
    taken = (ins[31:24] == 8'h06) || (ins[31:24] == 8'h07 && z);
    return taken ? seq + 32'(int'($signed(ins[23:16])) * 4) : seq;
  endfunction

  // Called at a falling edge with the DUT in FETCH; returns at the falling edge
  // of the following FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int stall);
    logic [7:0] op;
    logic       lg;
    logic [2:0] e_alu;
    logic       e_imm, e_neg, e_wr;
    op    = ins[31:24];
    lg    = (op < 8'd8);
    e_alu = lg ? alu_tab[op[2:0]] : 3'd0;
    e_imm = lg && imm_m[op[2:0]];
    e_neg = lg && neg_m[op[2:0]];
    e_wr  = lg && wr_m[op[2:0]];

    check("fetch_req", FETCH_REQ, 1);
    check("fetch_we", WRITEENABLE, 0);
    check("fetch_pc", PC, model_pc);
    check("fetch_aluop", ALUOP, 0);
    for (int i = 0; i < stall; i++) begin
      INSTR_VALID = 1'b0;
      INSTRUCTION = $urandom;
      @(negedge CLK);
      check("stall_req", FETCH_REQ, 1);
      check("stall_pc", PC, model_pc);
      check("stall_we", WRITEENABLE, 0);
    end
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    ZERO        = z;
    check("exec_rr1", READREG1, ins[10:8]);
    check("exec_rr2", READREG2, ins[2:0]);
    check("exec_wr", WRITEREG, ins[18:16]);
    check("exec_imm", IMMEDIATE, ins[7:0]);
    check("exec_aluop", ALUOP, e_alu);
    check("exec_immsel", IMM_SEL, e_imm);
    check("exec_negsel", NEG_SEL, e_neg);
    check("exec_we", WRITEENABLE, 0);
    check("exec_req", FETCH_REQ, 0);
    check("exec_trap", TRAP, 0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    if (!lg) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        check("halt_trap", TRAP, 1);
        check("halt_req", FETCH_REQ, 0);
        check("halt_we", WRITEENABLE, 0);
        check("halt_pc", PC, model_pc);
      end
      INSTR_VALID = 1'b0;
      RESET = 1'b0;
      #1;
      check("halt_rst_trap", TRAP, 0);
      check("halt_rst_pc", PC, 0);
      @(negedge CLK);
      RESET = 1'b1;
      model_pc = '0;
      return;
    end
`endif
    @(negedge CLK);
    check("wb_we", WRITEENABLE, e_wr);
    check("wb_aluop", ALUOP, e_alu);
    check("wb_wr", WRITEREG, ins[18:16]);
    check("wb_req", FETCH_REQ, 0);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    model_pc = next_pc(model_pc, ins, z);
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  op;
    int          sel;

    #2;
    check("rst_pc", PC, 0);
    check("rst_req", FETCH_REQ, 0);
    check("rst_we", WRITEENABLE, 0);
    check("rst_trap", TRAP, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rel_req", FETCH_REQ, 1);
    check("rel_pc", PC, 0);

    run_instr(32'h00040038, 1'b0, 0);   // loadi -> PC 4
    run_instr(32'h03010203, 1'b0, 5);   // sub after stall -> PC 8
    run_instr(32'h06FE0000, 1'b0, 0);   // j back to 4
    run_instr(32'h07030102, 1'b1, 0);   // beq taken -> 20
    run_instr(32'h06FB0000, 1'b1, 0);   // j back to 4
    run_instr(32'h07030102, 1'b0, 0);   // beq not taken -> 8
    run_instr(32'h06FC0000, 1'b0, 0);   // j to 0xFFFFFFFC
    check("wrap_setup_pc", PC, 32'hFFFFFFFC);
    run_instr(32'h02010203, 1'b0, 0);   // add wraps PC to 0
    run_instr(32'hFF000000, 1'b0, 0);   // illegal opcode

    // Reset abort in the middle of WB of an add
    check("abort_fetch_pc", PC, model_pc);
    INSTRUCTION = 32'h02050607;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    check("abort_wb_we", WRITEENABLE, 1);
    #2;
    RESET = 1'b0;
    #1;
    check("abort_we", WRITEENABLE, 0);
    check("abort_pc", PC, 0);
    check("abort_trap", TRAP, 0);
    check("abort_req", FETCH_REQ, 0);
    @(negedge CLK);
    RESET = 1'b1;
    model_pc = '0;
    #1;

    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel > 7) ? 8'($urandom_range(8, 255)) : 8'(sel);
      ins = {op, 24'($urandom)};
      run_instr(ins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
